// File: rtl/lvds_tx_word_framer_pkg.sv
// Shared definitions for the LVDS transmit word framer: framer states,
// symbol defaults and the word-to-byte helper used when serialising a frame.
package lvds_tx_word_framer_pkg;

  localparam int SYM_W_DEF  = 8;
  localparam int WORD_W     = 32;
  localparam int WORD_BYTES = 4;

  localparam logic [7:0] TRAIN_PAT_DEF = 8'hF0;
  localparam logic [7:0] SOF_SYM_DEF   = 8'hA5;
  localparam logic [7:0] IDLE_SYM_DEF  = 8'h3C;

  // Index of the first (most significant) byte sent after SOF
  localparam logic [1:0] LAST_BYTE_IDX = 2'(WORD_BYTES - 1);

  typedef enum logic [1:0] {
    ST_TRAIN = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SOF   = 2'd2,
    ST_DATA  = 2'd3
  } state_t;

  // Byte idx of a word, idx 3 being the most significant byte
  function automatic logic [7:0] word_byte(input logic [WORD_W-1:0] w, input logic [1:0] idx);
    logic [WORD_W-1:0] sh;
    sh = w >> {idx, 3'b000};
    return sh[7:0];
  endfunction

endpackage

// File: rtl/lvds_tx_word_framer_if.sv
// Put-style enqueue handshake between the core and the transmit framer.
interface lvds_tx_word_framer_if;
  import lvds_tx_word_framer_pkg::*;

  logic [WORD_W-1:0] enq_tx;
  logic              EN_enq_tx;
  logic              RDY_enq_tx;

  modport master (output enq_tx, output EN_enq_tx, input RDY_enq_tx);
  modport slave  (input enq_tx, input EN_enq_tx, output RDY_enq_tx);

endinterface

// File: rtl/lvds_tx_word_framer_fifo.sv
// Show-ahead word FIFO: head is visible without a read strobe, pop advances it.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module lvds_tx_word_framer_fifo
  import lvds_tx_word_framer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = WORD_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_wr_fire;
  logic             w_rd_fire;

  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign w_wr_fire = i_wr_en && !o_full;
  assign w_rd_fire = i_rd_en && !o_empty;
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

  // Storage write; contents need no reset since the pointers define validity
  always_ff @(posedge i_clk) begin
    if (w_wr_fire) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end
  end

  // Pointer update; a simultaneous write and pop leave the count unchanged
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_fire) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd_fire) r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/lvds_tx_word_framer.sv
// Transmit-side LVDS link framer: sends the training pattern until the far
// end reports alignment, then SOF + 4 data bytes (MSB first) per word, or IDLE.
// A frame interrupted by alignment loss is not popped and is resent in full.
module lvds_tx_word_framer
  import lvds_tx_word_framer_pkg::*;
#(
  parameter int               SYM_W     = SYM_W_DEF,
  parameter int               DEPTH     = 4,
  parameter logic [SYM_W-1:0] TRAIN_PAT = SYM_W'(TRAIN_PAT_DEF),
  parameter logic [SYM_W-1:0] SOF_SYM   = SYM_W'(SOF_SYM_DEF),
  parameter logic [SYM_W-1:0] IDLE_SYM  = SYM_W'(IDLE_SYM_DEF)
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  lvds_tx_word_framer_if.slave  enq_if,
  input  logic                  tx_align_done,
  output logic [SYM_W-1:0]      tx_data,
  output logic                  link_up,
  output logic [15:0]           words_sent
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  logic               r_sync1;
  logic               r_align_s;
  state_t             r_state;
  state_t             w_state_next;
  logic [1:0]         r_byte_idx;
  logic [1:0]         w_byte_idx_next;
  logic [SYM_W-1:0]   r_tx_data;
  logic [SYM_W-1:0]   w_tx_data_next;
  logic               r_link_up;
  logic [15:0]        r_words_sent;
  logic [15:0]        w_words_sent_next;
  logic               w_pop;
  logic               w_enq_fire;
  logic               w_more;
  logic [WORD_W-1:0]  w_head;
  logic               w_full;
  logic               w_empty;
  logic [AW:0]        w_count;

  lvds_tx_word_framer_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .i_clk     (CLK),
    .i_rst_n   (RST_N),
    .i_wr_en   (enq_if.EN_enq_tx),
    .i_wr_data (enq_if.enq_tx),
    .i_rd_en   (w_pop),
    .o_head    (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count)
  );

  assign enq_if.RDY_enq_tx = !w_full;
  assign w_enq_fire        = enq_if.EN_enq_tx && !w_full;
  // After popping the head, another word is ready if one more is stored or arrives now
  assign w_more            = (w_count > CNT_ONE) || w_enq_fire;

  assign tx_data    = r_tx_data;
  assign link_up    = r_link_up;
  assign words_sent = r_words_sent;

  // Bring the asynchronous alignment flag into the CLK domain
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_sync1   <= 1'b0;
      r_align_s <= 1'b0;
    end else begin
      r_sync1   <= tx_align_done;
      r_align_s <= r_sync1;
    end
  end

  // Next state, byte index, pop/count and the symbol for the current state
  always_comb begin
    w_state_next      = r_state;
    w_byte_idx_next   = r_byte_idx;
    w_words_sent_next = r_words_sent;
    w_pop             = 1'b0;
    w_tx_data_next    = TRAIN_PAT;
    case (r_state)
      ST_TRAIN: begin
        w_tx_data_next = TRAIN_PAT;
        if (r_align_s) w_state_next = ST_IDLE;
      end
      ST_IDLE: begin
        w_tx_data_next = IDLE_SYM;
        if (!r_align_s)    w_state_next = ST_TRAIN;
        else if (!w_empty) w_state_next = ST_SOF;
      end
      ST_SOF: begin
        w_tx_data_next = SOF_SYM;
        if (!r_align_s) begin
          w_state_next = ST_TRAIN;
        end else begin
          w_state_next    = ST_DATA;
          w_byte_idx_next = LAST_BYTE_IDX;
        end
      end
      ST_DATA: begin
        w_tx_data_next = SYM_W'(word_byte(w_head, r_byte_idx));
        if (!r_align_s) begin
          // Abort keeps the head word so it is resent after re-alignment
          w_state_next = ST_TRAIN;
        end else if (r_byte_idx == 2'd0) begin
          w_pop             = 1'b1;
          w_words_sent_next = r_words_sent + 16'd1;
          w_state_next      = w_more ? ST_SOF : ST_IDLE;
        end else begin
          w_byte_idx_next = r_byte_idx - 2'd1;
        end
      end
      default: begin
        w_state_next = ST_TRAIN;
      end
    endcase
  end

  // Framer state, registered symbol output, link status and frame counter
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state      <= ST_TRAIN;
      r_byte_idx   <= 2'd0;
      r_tx_data    <= TRAIN_PAT;
      r_link_up    <= 1'b0;
      r_words_sent <= 16'd0;
    end else begin
      r_state      <= w_state_next;
      r_byte_idx   <= w_byte_idx_next;
      r_tx_data    <= w_tx_data_next;
      r_link_up    <= (w_state_next != ST_TRAIN);
      r_words_sent <= w_words_sent_next;
    end
  end

endmodule

// File: tb/tb_lvds_tx_word_framer.sv
// Bench for lvds_tx_word_framer: directed scenarios plus a randomized run.
// The reference is a receiver-side stream parser: it recovers frames from
// tx_data and matches them in order against the words accepted by the DUT.
module tb_lvds_tx_word_framer;
  import lvds_tx_word_framer_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [7:0] F0 = 8'hF0;
  localparam logic [7:0] A5 = 8'hA5;
  localparam logic [7:0] IDL = 8'h3C;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        tx_align_done;
  logic [7:0]  tx_data;
  logic        link_up;
  logic [15:0] words_sent;

  lvds_tx_word_framer_if enq_if ();

  lvds_tx_word_framer #(.DEPTH(DEPTH)) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .enq_if        (enq_if),
    .tx_align_done (tx_align_done),
    .tx_data       (tx_data),
    .link_up       (link_up),
    .words_sent    (words_sent)
  );

  always #5 CLK = ~CLK;

  int          checks = 0;
  int          fails  = 0;
  logic [31:0] exp_q[$];
  bit          in_frame = 0;
  bit          pending  = 0;
  int          nb = 0;
  logic [31:0] acc = '0;
  logic [15:0] m_sent = '0;
  bit          gap_chk = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    for (int b = 0; b < 4; b++) if (w[8*b +: 8] == F0) w[8*b +: 8] = 8'h0F;
    return w;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    in_frame = 0;
    pending  = 0;
    nb       = 0;
    m_sent   = '0;
  endtask

  // Receiver view: a frame of SOF + 4 bytes counts once the following symbol
  // shows the link stayed up (anything but the training pattern).
  task automatic parse(input logic [7:0] s);
    if (in_frame) begin
      if (s == F0) begin
        in_frame = 0;
      end else begin
        acc = {acc[23:0], s};
        nb++;
        if (nb == 4) begin
          in_frame = 0;
          pending  = 1;
        end
      end
    end else begin
      if (pending) begin
        pending = 0;
        if (s != F0) begin
          check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            check("frame_word", acc, exp_q[0]);
            void'(exp_q.pop_front());
          end
          m_sent = m_sent + 16'd1;
          check("words_sent", words_sent, m_sent);
          if (gap_chk && exp_q.size() != 0) check("no_idle_gap", s, A5);
        end
      end
      if (s == A5) begin
        in_frame = 1;
        nb       = 0;
        acc      = '0;
      end else begin
        check("link_symbol", 32'((s == F0) || (s == IDL)), 32'd1);
      end
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    parse(tx_data);
  endtask

  task automatic drive_enq(input bit en, input logic [31:0] w);
    enq_if.EN_enq_tx = en;
    enq_if.enq_tx    = w;
    if (en && enq_if.RDY_enq_tx) exp_q.push_back(w);
  endtask

  task automatic drain(input string tag, input int bound);
    int n = 0;
    while (!(exp_q.size() == 0 && !in_frame && !pending) && n < bound) begin
      step();
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  task automatic wait_sym(input string tag, input logic [7:0] sym, input int bound);
    int n = 0;
    while (tx_data != sym && n < bound) begin
      step();
      n++;
    end
    check(tag, tx_data, sym);
  endtask

  initial begin
    logic [7:0]  t2_exp [8];
    logic [31:0] w3 [5];
    int          tries;
    bit          ok;
    int          n;

    t2_exp = '{8'h3C, 8'h3C, 8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h3C};
    RST_N = 1'b0;
    tx_align_done = 1'b0;
    drive_enq(0, '0);
    step();
    step();
    RST_N = 1'b1;
    model_reset();

    // Reset state and training with alignment low
    check("reset_words_sent", words_sent, 16'd0);
    for (int i = 0; i < 20; i++) begin
      step();
      check("train_tx", tx_data, F0);
      check("train_link_up", link_up, 1'b0);
      check("train_rdy", enq_if.RDY_enq_tx, 1'b1);
    end

    // Alignment, then a single word with its exact symbol timing
    tx_align_done = 1'b1;
    n = 0;
    while (!link_up && n < 10) begin step(); n++; end
    check("t2_link_up", link_up, 1'b1);
    step();
    check("t2_idle", tx_data, IDL);
    drive_enq(1, 32'hDEADBEEF);
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 0) drive_enq(0, '0);
      check("t2_stream", tx_data, t2_exp[i]);
    end
    check("t2_words_sent", words_sent, 16'd1);

    // DEPTH+1 words back to back: fifth is held off, frames contiguous
    gap_chk = 1;
    for (int i = 0; i < 5; i++) w3[i] = rand_word();
    for (int i = 0; i < 5; i++) begin
      tries = 0;
      ok    = 0;
      while (!ok && tries < 50) begin
        ok = enq_if.RDY_enq_tx;
        drive_enq(1, w3[i]);
        step();
        tries++;
      end
      check("t3_accepted", ok, 1'b1);
      if (i == 3) check("t3_rdy_full", enq_if.RDY_enq_tx, 1'b0);
      if (i == 4) check("t3_fifth_held", 32'(tries > 1), 32'd1);
    end
    drive_enq(0, '0);
    drain("t3_drain", 100);
    check("t3_words_sent", words_sent, 16'd6);
    gap_chk = 0;

    // Alignment loss inside a frame: abort to training, resend in full
    drive_enq(1, 32'h12345678);
    step();
    drive_enq(0, '0);
    wait_sym("t4_sof", A5, 10);
    tx_align_done = 1'b0;
    wait_sym("t4_train", F0, 6);
    check("t4_link_down", link_up, 1'b0);
    check("t4_not_counted", words_sent, 16'd6);
    tx_align_done = 1'b1;
    drain("t4_resend", 40);
    check("t4_words_sent", words_sent, 16'd7);

    // Enqueue on a full FIFO is ignored
    tx_align_done = 1'b0;
    for (int i = 0; i < 8; i++) step();
    for (int i = 0; i < DEPTH; i++) begin
      drive_enq(1, rand_word());
      step();
    end
    check("t5_full", enq_if.RDY_enq_tx, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive_enq(1, 32'hBAD0BAD0);
      step();
      check("t5_rdy_low", enq_if.RDY_enq_tx, 1'b0);
    end
    drive_enq(0, '0);
    tx_align_done = 1'b1;
    drain("t5_drain", 100);
    check("t5_words_sent", words_sent, 16'd11);

    // Counter wrap
    force dut.r_words_sent = 16'hFFFF;
    step();
    release dut.r_words_sent;
    m_sent = 16'hFFFF;
    check("t6_preload", words_sent, 16'hFFFF);
    drive_enq(1, rand_word());
    step();
    drive_enq(0, '0);
    drain("t6_wrap_drain", 40);
    check("t6_wrapped", words_sent, 16'h0000);

    // Reset in the middle of a data byte
    drive_enq(1, rand_word());
    step();
    drive_enq(1, rand_word());
    step();
    drive_enq(0, '0);
    wait_sym("t6_sof", A5, 10);
    step();
    RST_N = 1'b0;
    step();
    model_reset();
    check("t6_rst_tx", tx_data, F0);
    check("t6_rst_link", link_up, 1'b0);
    check("t6_rst_words", words_sent, 16'd0);
    check("t6_rst_rdy", enq_if.RDY_enq_tx, 1'b1);
    RST_N = 1'b1;
    for (int i = 0; i < 15; i++) step();
    check("t6_post_rst_idle", tx_data, IDL);
    check("t6_post_rst_words", words_sent, 16'd0);

    // Randomized traffic with random alignment drops
    for (int c = 0; c < 1500; c++) begin
      if (tx_align_done && $urandom_range(0, 299) == 0) tx_align_done = 1'b0;
      else if (!tx_align_done && $urandom_range(0, 19) == 0) tx_align_done = 1'b1;
      drive_enq(1'($urandom_range(0, 1)), rand_word());
      step();
    end
    drive_enq(0, '0);
    tx_align_done = 1'b1;
    drain("rand_drain", 200);
    check("rand_words_sent", words_sent, m_sent);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
